acc_cmem_responder: RTL

ACC_CMEM_RESPONDER -- requirements
Module: acc_cmem_responder

---
 rtl/acc_pkg.sv | 11 +
 rtl/acc_cmem_responder_if.sv | 56 +++++
 rtl/acc_cmem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator types: address width and memory request kind.
package acc_pkg;

    localparam int unsigned AddrWidth = 32;

    typedef enum logic [0:0] {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_req_type_e;

endpackage

// File: rtl/acc_cmem_responder_if.sv
// Cmem request/response channel plus OBI-style data port of the responder.
interface acc_cmem_responder_if #(
    parameter int unsigned AddrWidth = acc_pkg::AddrWidth
) ();

    logic                      cmem_q_valid_i;
    logic                      cmem_q_ready_o;
    logic [31:0]               cmem_q_laddr_i;
    logic [31:0]               cmem_q_wdata_i;
    logic [2:0]                cmem_q_width_i;
    acc_pkg::mem_req_type_e    cmem_q_req_type_i;
    logic                      cmem_q_mode_i;
    logic                      cmem_q_spec_i;
    logic                      cmem_q_endoftransaction_i;
    logic [31:0]               cmem_q_hart_id_i;
    logic [AddrWidth-1:0]      cmem_q_addr_i;

    logic                      cmem_p_valid_o;
    logic                      cmem_p_ready_i;
    logic [31:0]               cmem_p_rdata_o;
    logic [4:0]                cmem_p_range_o;
    logic                      cmem_p_status_o;
    logic [AddrWidth-1:0]      cmem_p_addr_o;
    logic [31:0]               cmem_p_hart_id_o;

    logic                      data_req_o;
    logic                      data_gnt_i;
    logic [31:0]               data_addr_o;
    logic                      data_we_o;
    logic [3:0]                data_be_o;
    logic [31:0]               data_wdata_o;
    logic                      data_rvalid_i;
    logic [31:0]               data_rdata_i;
    logic                      data_err_i;

    modport slave (
        input  cmem_q_valid_i, cmem_q_laddr_i, cmem_q_wdata_i, cmem_q_width_i,
               cmem_q_req_type_i, cmem_q_mode_i, cmem_q_spec_i,
               cmem_q_endoftransaction_i, cmem_q_hart_id_i, cmem_q_addr_i,
               cmem_p_ready_i, data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        output cmem_q_ready_o, cmem_p_valid_o, cmem_p_rdata_o, cmem_p_range_o,
               cmem_p_status_o, cmem_p_addr_o, cmem_p_hart_id_o,
               data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
    );

    modport master (
        output cmem_q_valid_i, cmem_q_laddr_i, cmem_q_wdata_i, cmem_q_width_i,
               cmem_q_req_type_i, cmem_q_mode_i, cmem_q_spec_i,
               cmem_q_endoftransaction_i, cmem_q_hart_id_i, cmem_q_addr_i,
               cmem_p_ready_i, data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  cmem_q_ready_o, cmem_p_valid_o, cmem_p_rdata_o, cmem_p_range_o,
               cmem_p_status_o, cmem_p_addr_o, cmem_p_hart_id_o,
               data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
    );

endinterface

// File: rtl/acc_cmem_responder.sv
// Single-outstanding bridge from Cmem requests to an OBI data port, with
// sub-word lane steering and NaN-boxed read data.
module acc_cmem_responder #(
    parameter int unsigned AddrWidth = acc_pkg::AddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    acc_cmem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_e;

    state_e               state_r;
    state_e               state_s;
    logic                 accept_s;
    logic                 legal_s;
    logic                 capture_rsp_s;
    logic [31:0]          rdata_s;
    logic                 unused_meta_s;

    logic                 q_ready_r;
    logic [31:0]          laddr_r;
    logic [31:0]          wdata_r;
    logic [2:0]           width_r;
    logic                 we_r;
    logic [31:0]          hart_id_r;
    logic [AddrWidth-1:0] addr_r;
    logic [31:0]          rdata_r;
    logic                 status_r;

    function automatic logic width_legal(input logic [2:0] width, input logic [1:0] off);
        case (width)
            3'b000:  width_legal = 1'b1;
            3'b001:  width_legal = (off[0] == 1'b0);
            3'b010:  width_legal = (off == 2'b00);
            default: width_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] width, input logic [1:0] off);
        case (width)
            3'b000:  byte_enable = 4'b0001 << off;
            3'b001:  byte_enable = 4'b0011 << off;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    // Align the addressed lanes to bit 0 and fill everything above the access with ones.
    function automatic logic [31:0] nan_box(input logic [31:0] raw, input logic [2:0] width,
                                            input logic [1:0] off);
        logic [31:0] shifted;
        shifted = raw >> {off, 3'b000};
        case (width)
            3'b000:  nan_box = {24'hFF_FFFF, shifted[7:0]};
            3'b001:  nan_box = {16'hFFFF, shifted[15:0]};
            default: nan_box = shifted;
        endcase
    endfunction

    function automatic logic [4:0] range_of(input logic [2:0] width);
        case (width)
            3'b000:  range_of = 5'd7;
            3'b001:  range_of = 5'd15;
            default: range_of = 5'd31;
        endcase
    endfunction

    // Mode, speculation and end-of-transaction flags are accepted but carry no behaviour.
    assign unused_meta_s = ^{bus.cmem_q_mode_i, bus.cmem_q_spec_i, bus.cmem_q_endoftransaction_i};

    // Next-state logic; illegal requests skip the data port and go straight to a response.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        legal_s  = width_legal(bus.cmem_q_width_i, bus.cmem_q_laddr_i[1:0]);
        case (state_r)
            IDLE: begin
                if (bus.cmem_q_valid_i && q_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = legal_s ? REQ : RSP;
                end else begin
                    state_s  = IDLE;
                end
            end
            REQ: begin
                if (bus.data_gnt_i) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (bus.data_rvalid_i) begin
                    state_s = RSP;
                end else begin
                    state_s = WAIT;
                end
            end
            RSP: begin
                if (bus.cmem_p_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Read data for the response; writes and bus errors return zero.
    always_comb begin
        capture_rsp_s = (state_r == WAIT) && bus.data_rvalid_i;
        if (capture_rsp_s && !bus.data_err_i && !we_r) begin
            rdata_s = nan_box(bus.data_rdata_i, width_r, laddr_r[1:0]);
        end else begin
            rdata_s = 32'h0;
        end
    end

    // State, request capture and response capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            q_ready_r <= 1'b0;
            laddr_r   <= 32'h0;
            wdata_r   <= 32'h0;
            width_r   <= 3'b000;
            we_r      <= 1'b0;
            hart_id_r <= 32'h0;
            addr_r    <= '0;
            rdata_r   <= 32'h0;
            status_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            q_ready_r <= (state_s == IDLE);
            if (accept_s) begin
                laddr_r   <= bus.cmem_q_laddr_i;
                wdata_r   <= bus.cmem_q_wdata_i;
                width_r   <= bus.cmem_q_width_i;
                we_r      <= (bus.cmem_q_req_type_i == acc_pkg::WRITE);
                hart_id_r <= bus.cmem_q_hart_id_i;
                addr_r    <= bus.cmem_q_addr_i;
                rdata_r   <= 32'h0;
                status_r  <= ~legal_s;
            end else if (capture_rsp_s) begin
                rdata_r   <= rdata_s;
                status_r  <= bus.data_err_i;
            end else begin
                rdata_r   <= rdata_r;
                status_r  <= status_r;
            end
        end
    end

    // Output decode from registered state; idle channels are forced to zero.
    always_comb begin
        bus.cmem_q_ready_o = q_ready_r;
        if (state_r == REQ) begin
            bus.data_req_o   = 1'b1;
            bus.data_addr_o  = {laddr_r[31:2], 2'b00};
            bus.data_we_o    = we_r;
            bus.data_be_o    = byte_enable(width_r, laddr_r[1:0]);
            bus.data_wdata_o = wdata_r << {laddr_r[1:0], 3'b000};
        end else begin
            bus.data_req_o   = 1'b0;
            bus.data_addr_o  = 32'h0;
            bus.data_we_o    = 1'b0;
            bus.data_be_o    = 4'b0000;
            bus.data_wdata_o = 32'h0;
        end
        if (state_r == RSP) begin
            bus.cmem_p_valid_o   = 1'b1;
            bus.cmem_p_rdata_o   = rdata_r;
            bus.cmem_p_range_o   = range_of(width_r);
            bus.cmem_p_status_o  = status_r;
            bus.cmem_p_addr_o    = addr_r;
            bus.cmem_p_hart_id_o = hart_id_r;
        end else begin
            bus.cmem_p_valid_o   = 1'b0;
            bus.cmem_p_rdata_o   = 32'h0;
            bus.cmem_p_range_o   = 5'd0;
            bus.cmem_p_status_o  = 1'b0;
            bus.cmem_p_addr_o    = '0;
            bus.cmem_p_hart_id_o = 32'h0;
        end
    end

endmodule
